// File: rtl/linear_layer_engine_pkg.sv
// Shared types and helpers for the linear layer engine: FSM states,
// default geometry and the saturation limits used by requantisation.
package linear_layer_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  localparam int DEF_N   = 4;
  localparam int DEF_M   = 4;
  localparam int DEF_MUL = 4;
  localparam int CHUNKS  = DEF_N / DEF_MUL;
  localparam int C       = DEF_M * CHUNKS;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic longint sat_hi(input int prec);
    return (longint'(1) << (prec - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int prec);
    return -(longint'(1) << (prec - 1));
  endfunction

endpackage

// File: rtl/linear_layer_engine_if.sv
// Handshake bundle of the linear layer: feature input, result output and
// the weight/bias write port. The engine sits on the slave side.
interface linear_layer_if #(
  parameter int PRECISION      = 8,
  parameter int BIAS_PRECISION = 32,
  parameter int NUM_FEATURES   = 2,
  parameter int N              = 4,
  parameter int M              = 4
);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic                                         in_valid;
  logic                                         in_ready;
  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] features;
  logic                                         relu_en;
  logic                                         out_valid;
  logic                                         out_ready;
  logic [NUM_FEATURES-1:0][M-1:0][PRECISION-1:0] out;
  logic                                         wr_valid;
  logic                                         wr_ready;
  logic                                         wr_is_bias;
  logic [RW-1:0]                                wr_row;
  logic [CW-1:0]                                wr_col;
  logic [BIAS_PRECISION-1:0]                    wr_data;

  modport master (
    output in_valid, features, relu_en, out_ready,
    output wr_valid, wr_is_bias, wr_row, wr_col, wr_data,
    input  in_ready, out_valid, out, wr_ready
  );

  modport slave (
    input  in_valid, features, relu_en, out_ready,
    input  wr_valid, wr_is_bias, wr_row, wr_col, wr_data,
    output in_ready, out_valid, out, wr_ready
  );
endinterface

// File: rtl/linear_layer_engine_requant.sv
// Combinational requantiser: floor shift, optional ReLU, saturation to the
// signed output width.
module linear_requant
  import linear_layer_pkg::*;
#(
  parameter int PRECISION      = 8,
  parameter int BIAS_PRECISION = 32,
  parameter int OUT_SHIFT      = 0
) (
  input  logic signed [BIAS_PRECISION-1:0] acc_i,
  input  logic                             relu_en_i,
  output logic signed [PRECISION-1:0]      res_o
);
  localparam logic signed [BIAS_PRECISION-1:0] HI = BIAS_PRECISION'(sat_hi(PRECISION));
  localparam logic signed [BIAS_PRECISION-1:0] LO = BIAS_PRECISION'(sat_lo(PRECISION));

  logic signed [BIAS_PRECISION-1:0] v;

  always_comb begin
    v = acc_i >>> OUT_SHIFT;
    if (relu_en_i && (v < 0)) v = '0;
    if (v > HI)      res_o = HI[PRECISION-1:0];
    else if (v < LO) res_o = LO[PRECISION-1:0];
    else             res_o = v[PRECISION-1:0];
  end
endmodule

// File: rtl/linear_layer_engine.sv
// Time-multiplexed linear layer: M rows x N/MUL_PER_FEATURE chunks per input,
// result held in DONE until out_ready; weights live in flops for parallel reads.
module linear_layer_engine
  import linear_layer_pkg::*;
#(
  parameter int PRECISION       = 8,
  parameter int BIAS_PRECISION  = 32,
  parameter int NUM_FEATURES    = 2,
  parameter int MUL_PER_FEATURE = 4,
  parameter int N               = 4,
  parameter int M               = 4,
  parameter int OUT_SHIFT       = 0
) (
  input logic           clk,
  input logic           rst,
  input logic           ce,
  linear_layer_if.slave bus
);
  localparam int NCHUNK = N / MUL_PER_FEATURE;
  localparam int RW     = clog2_min1(M);
  localparam int KW     = clog2_min1(NCHUNK);
  localparam int IW     = clog2_min1(N);

  if (N % MUL_PER_FEATURE != 0) begin : g_bad_mul
    $error("MUL_PER_FEATURE must divide N");
  end

  state_e                                       state_q, state_d;
  logic [RW-1:0]                                row_q, row_d;
  logic [KW-1:0]                                chunk_q, chunk_d;
  logic                                         in_fire, wr_fire, step, last_chunk;
  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] feat_q;
  logic                                         relu_q;
  logic signed [PRECISION-1:0]                  w_q   [M][N];
  logic signed [BIAS_PRECISION-1:0]             b_q   [M];
  logic signed [BIAS_PRECISION-1:0]             acc_q [NUM_FEATURES];
  logic signed [BIAS_PRECISION-1:0]             sum_d [NUM_FEATURES];
  logic signed [PRECISION-1:0]                  req_d [NUM_FEATURES];
  logic [NUM_FEATURES-1:0][M-1:0][PRECISION-1:0] out_q;

  function automatic logic signed [2*PRECISION-1:0] smul(input logic signed [PRECISION-1:0] a,
                                                         input logic signed [PRECISION-1:0] b);
    return a * b;
  endfunction

  function automatic logic [IW-1:0] col_of(input logic [KW-1:0] k, input int j);
    return IW'(int'(k) * MUL_PER_FEATURE + j);
  endfunction

  assign bus.in_ready  = (state_q == IDLE) && ce && !rst;
  assign bus.wr_ready  = (state_q == IDLE) && ce && !rst;
  assign bus.out_valid = (state_q == DONE) && !rst;
  assign bus.out       = out_q;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign wr_fire       = bus.wr_valid && bus.wr_ready;
  assign last_chunk    = (chunk_q == KW'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    chunk_d = chunk_q;
    step    = 1'b0;
    unique case (state_q)
      IDLE: if (in_fire) begin
        state_d = COMPUTE;
        row_d   = '0;
        chunk_d = '0;
      end
      COMPUTE: if (ce) begin
        step = 1'b1;
        if (last_chunk) begin
          chunk_d = '0;
          if (row_q == RW'(M - 1)) state_d = DONE;
          else                     row_d   = row_q + 1'b1;
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
      DONE: if (bus.out_ready && ce) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      chunk_q <= '0;
    end else if (ce) begin
      state_q <= state_d;
      row_q   <= row_d;
      chunk_q <= chunk_d;
    end
  end

  // First chunk of a row seeds from the bias instead of the running sum.
  always_comb begin
    for (int f = 0; f < NUM_FEATURES; f++) begin
      logic signed [BIAS_PRECISION-1:0] s;
      s = (chunk_q == '0) ? b_q[row_q] : acc_q[f];
      for (int j = 0; j < MUL_PER_FEATURE; j++) begin
        s = s + BIAS_PRECISION'(smul(feat_q[f][col_of(chunk_q, j)],
                                     w_q[row_q][col_of(chunk_q, j)]));
      end
      sum_d[f] = s;
    end
  end

  for (genvar g = 0; g < NUM_FEATURES; g++) begin : g_rq
    linear_requant #(
      .PRECISION     (PRECISION),
      .BIAS_PRECISION(BIAS_PRECISION),
      .OUT_SHIFT     (OUT_SHIFT)
    ) u_rq (
      .acc_i    (sum_d[g]),
      .relu_en_i(relu_q),
      .res_o    (req_d[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < M; m++) begin
        b_q[m] <= '0;
        for (int n = 0; n < N; n++) w_q[m][n] <= '0;
      end
      for (int f = 0; f < NUM_FEATURES; f++) acc_q[f] <= '0;
      feat_q <= '0;
      relu_q <= 1'b0;
      out_q  <= '0;
    end else begin
      if (wr_fire && (int'(bus.wr_row) < M)) begin
        if (bus.wr_is_bias)            b_q[bus.wr_row]             <= bus.wr_data;
        else if (int'(bus.wr_col) < N) w_q[bus.wr_row][bus.wr_col] <= bus.wr_data[PRECISION-1:0];
      end
      if (in_fire) begin
        feat_q <= bus.features;
        relu_q <= bus.relu_en;
      end
      if (step) begin
        for (int f = 0; f < NUM_FEATURES; f++) begin
          acc_q[f] <= sum_d[f];
          if (last_chunk) out_q[f][row_q] <= req_d[f];
        end
      end
    end
  end
endmodule

// File: tb/tb_linear_layer_engine.sv
// Directed bench driving three engine variants in lockstep: default,
// MUL_PER_FEATURE=2 and OUT_SHIFT=2, all sharing one stimulus stream.
module tb_linear_layer_engine;
  typedef logic [1:0][3:0][7:0] outv_t;

  logic        clk = 1'b0;
  logic        rst, ce;
  logic        in_valid, relu_en, out_ready, wr_valid, wr_is_bias;
  logic [1:0][3:0][7:0] features;
  logic [1:0]  wr_row, wr_col;
  logic [31:0] wr_data;
  logic [2:0]  ov, ir, wrr;
  outv_t [2:0] outs;
  int          tests = 0;
  int          failed = 0;
  int          na, nb, nc;
  int          fa [2][4] = '{'{6, 5, 1, 4}, '{3, 2, 1, 6}};
  int          fc [2][4] = '{'{1, 1, 0, 1}, '{0, 0, 0, 1}};

  always #5 clk = ~clk;

  linear_layer_if #(.PRECISION(8), .BIAS_PRECISION(32), .NUM_FEATURES(2), .N(4), .M(4)) bus [3] ();

  for (genvar i = 0; i < 3; i++) begin : g_dut
    linear_layer_engine #(
      .PRECISION(8), .BIAS_PRECISION(32), .NUM_FEATURES(2),
      .MUL_PER_FEATURE((i == 1) ? 2 : 4), .N(4), .M(4),
      .OUT_SHIFT((i == 2) ? 2 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .ce(ce), .bus(bus[i])
    );
    assign bus[i].in_valid   = in_valid;
    assign bus[i].features   = features;
    assign bus[i].relu_en    = relu_en;
    assign bus[i].out_ready  = out_ready;
    assign bus[i].wr_valid   = wr_valid;
    assign bus[i].wr_is_bias = wr_is_bias;
    assign bus[i].wr_row     = wr_row;
    assign bus[i].wr_col     = wr_col;
    assign bus[i].wr_data    = wr_data;
    assign ov[i]   = bus[i].out_valid;
    assign ir[i]   = bus[i].in_ready;
    assign wrr[i]  = bus[i].wr_ready;
    assign outs[i] = bus[i].out;
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_el(input string tag, input int d, input int f, input int m, input int exp);
    check($sformatf("%s_d%0d_f%0d_m%0d", tag, d, f, m), $signed(outs[d][f][m]), exp);
  endtask

  task automatic wr(input bit is_bias, input int row, input int col, input int data);
    wr_valid   = 1'b1;
    wr_is_bias = is_bias;
    wr_row     = row[1:0];
    wr_col     = col[1:0];
    wr_data    = data;
    tick();
    wr_valid   = 1'b0;
  endtask

  task automatic set_feat(input int f, input int v0, input int v1, input int v2, input int v3);
    features[f][0] = v0[7:0];
    features[f][1] = v1[7:0];
    features[f][2] = v2[7:0];
    features[f][3] = v3[7:0];
  endtask

  task automatic start(input bit relu);
    check("start_rdy", ir, 7);
    in_valid = 1'b1;
    relu_en  = relu;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic measure(input int gap_at, input int gap_len, output int a, output int b, output int c);
    a = -1; b = -1; c = -1;
    for (int n = 1; n <= 60; n++) begin
      ce = !((n > gap_at) && (n <= gap_at + gap_len));
      tick();
      if (ov[0] && a < 0) a = n;
      if (ov[1] && b < 0) b = n;
      if (ov[2] && c < 0) c = n;
      if (a >= 0 && b >= 0 && c >= 0) break;
    end
    ce = 1'b1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
    wr_valid = 1'b0; wr_is_bias = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    features = '0;

    // Reset and idle handshake
    repeat (3) tick();
    check("rst_out_valid", ov, 0);
    check("rst_out_a", outs[0], 0);
    check("rst_out_b", outs[1], 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", ir, 7);
    check("idle_wr_ready", wrr, 7);

    // Identity weights: output mirrors input
    for (int m = 0; m < 4; m++) wr(1'b0, m, m, 1);
    set_feat(0, 6, 5, 1, 4);
    set_feat(1, 3, 2, 1, 6);
    start(1'b0);
    measure(0, 0, na, nb, nc);
    check("id_lat_mul4", na, 4);
    check("id_lat_mul2", nb, 8);
    check("id_lat_shift", nc, 4);
    for (int f = 0; f < 2; f++)
      for (int m = 0; m < 4; m++) begin
        chk_el("id", 0, f, m, fa[f][m]);
        chk_el("id", 1, f, m, fa[f][m]);
        chk_el("id", 2, f, m, fc[f][m]);
      end
    drain();

    // Saturation and ReLU
    for (int m = 0; m < 4; m++)
      for (int n = 0; n < 4; n++) wr(1'b0, m, n, 1);
    wr(1'b1, 0, 0, 200);
    wr(1'b1, 1, 0, -300);
    set_feat(0, 4, 4, 4, 4);
    set_feat(1, 1, 1, 1, 1);
    start(1'b0);
    measure(0, 0, na, nb, nc);
    chk_el("sat", 0, 0, 0, 127);
    chk_el("sat", 0, 0, 1, -128);
    chk_el("sat", 0, 0, 2, 16);
    chk_el("sat", 0, 1, 0, 127);
    chk_el("sat", 0, 1, 1, -128);
    chk_el("sat", 0, 1, 3, 4);
    chk_el("sat", 1, 0, 1, -128);
    drain();
    start(1'b1);
    measure(0, 0, na, nb, nc);
    chk_el("relu", 0, 0, 0, 127);
    chk_el("relu", 0, 0, 1, 0);
    chk_el("relu", 0, 1, 1, 0);
    chk_el("relu", 0, 0, 2, 16);
    drain();
    wr(1'b1, 0, 0, 0);
    start(1'b0);
    measure(0, 0, na, nb, nc);
    chk_el("shift", 0, 0, 0, 16);
    chk_el("shift", 2, 0, 0, 4);
    chk_el("shift", 2, 0, 1, -71);
    chk_el("shift", 2, 1, 1, -74);
    chk_el("shift", 2, 1, 0, 1);
    drain();

    // Clock-enable gap of 3 cycles mid-compute
    start(1'b0);
    measure(1, 3, na, nb, nc);
    check("ce_lat_mul4", na, 7);
    check("ce_lat_mul2", nb, 11);
    check("ce_lat_shift", nc, 7);
    chk_el("ce", 0, 0, 0, 16);
    chk_el("ce", 0, 0, 1, -128);
    chk_el("ce", 0, 1, 3, 4);

    // Backpressure in DONE with a write attempt that must be refused
    wr_valid = 1'b1; wr_is_bias = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 100;
    for (int t = 0; t < 10; t++) begin
      tick();
      check("bp_out_valid", ov, 7);
      check("bp_in_ready", ir, 0);
      check("bp_wr_ready", wrr, 0);
      chk_el("bp", 0, 0, 0, 16);
      chk_el("bp", 0, 0, 1, -128);
    end
    wr_valid = 1'b0;
    drain();
    start(1'b0);
    measure(0, 0, na, nb, nc);
    chk_el("bp_after", 0, 0, 0, 16);
    chk_el("bp_after", 1, 0, 0, 16);
    drain();

    // Reset during compute clears weights and returns to IDLE
    set_feat(0, 6, 5, 1, 4);
    set_feat(1, 3, 2, 1, 6);
    start(1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mrst_in_ready", ir, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mrst_out_valid", ov, 0);
    check("mrst_idle", ir, 7);
    start(1'b0);
    measure(0, 0, na, nb, nc);
    check("mrst_lat", na, 4);
    check("mrst_out_a", outs[0], 0);
    check("mrst_out_b", outs[1], 0);
    drain();

    // Write and input in the same cycle: the write is already visible
    wr_valid = 1'b1; wr_is_bias = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 1;
    in_valid = 1'b1; relu_en = 1'b0;
    tick();
    wr_valid = 1'b0; in_valid = 1'b0;
    measure(0, 0, na, nb, nc);
    chk_el("same", 0, 0, 0, 6);
    chk_el("same", 0, 1, 0, 3);
    chk_el("same", 0, 0, 1, 0);
    chk_el("same", 1, 1, 0, 3);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
